// File: rtl/memory_bus_pkg.sv
// memory_bus_pkg
//   Shared types and helpers for the MemoryBus arbiter slice.
//   - BUS_*_WIDTH : bus widths that the request/response records are built on.
//                   The arbiter's width parameters default to these values and
//                   must be kept equal to them.
//   - req_state_t : occupancy of the one-entry request stage.
//   - bus_req_t   : a registered downstream request (address, data, write, id).
//   - bus_resp_t  : a registered upstream response (id, data).
//   - id_width(n) : index width needed to number n masters (at least 1 bit).
package memory_bus_pkg;

  localparam int BUS_ADDRESS_WIDTH = 32;
  localparam int BUS_DATA_WIDTH    = 24;
  localparam int BUS_ID_WIDTH      = 4;

  typedef enum logic {
    REQ_EMPTY = 1'b0,
    REQ_FULL  = 1'b1
  } req_state_t;

  typedef struct packed {
    logic [BUS_ADDRESS_WIDTH-1:0] address;
    logic [BUS_DATA_WIDTH-1:0]    data;
    logic                         write;
    logic [BUS_ID_WIDTH-1:0]      id;
  } bus_req_t;

  typedef struct packed {
    logic [BUS_ID_WIDTH-1:0]   id;
    logic [BUS_DATA_WIDTH-1:0] data;
  } bus_resp_t;

  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
//   Purely combinational round-robin pick: grants the first requester found
//   at or after the pointer, wrapping modulo N.
//   Ports:
//     req         in  [N]      request mask (already filtered by the caller)
//     ptr         in  [PTR_W]  index searched first; always < N
//     grant       out [N]      one-hot grant, all zeros when nothing requests
//     grant_idx   out [PTR_W]  index of the granted requester
//     grant_valid out 1        some requester was granted
module rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [PTR_W-1:0] grant_idx,
  output logic             grant_valid
);

  // Walk the N candidate slots starting at the pointer; the first hit wins
  // and later hits are ignored via grant_valid.
  always_comb begin
    int               idx;
    logic [PTR_W-1:0] sel;
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    idx         = 0;
    sel         = '0;
    for (int off = 0; off < N; off++) begin
      idx = int'(ptr) + off;
      if (idx >= N) idx = idx - N;
      sel = PTR_W'(idx);
      if (!grant_valid && req[sel]) begin
        grant_valid = 1'b1;
        grant[sel]  = 1'b1;
        grant_idx   = sel;
      end
    end
  end

endmodule

// File: rtl/memory_bus_arbiter.sv
// memory_bus_arbiter
//   Funnels NUM_MASTERS MemoryBus masters onto one memory-controller slave
//   port. Round-robin request arbitration into a one-entry registered request
//   stage, and a one-entry registered response stage routed back by ID.
//   Each request is stamped with the granting port index as msID; the slave
//   echoes it as smID, so every upstream master's MASTER_ID must equal its
//   port index.
//   Optional feature macro: MEMORY_BUS_ARBITER_READ_LIMIT_EN
//     When defined, each master may have at most MAX_OUTSTANDING reads in
//     flight; a master at its limit is masked from arbitration for reads.
//   Ports:
//     clock, reset             rising-edge clock, synchronous active-high reset
//     mMsValid/mMsTaken        per-master request handshake (taken is one-hot)
//     mMsAddress/mMsData/mMsWrite  per-master request payload
//     mSmValid/mSmID/mSmData   broadcast response to all masters
//     mSmTaken                 per-master response accept
//     msValid/msTaken          downstream request handshake
//     msAddress/msData/msWrite/msID  downstream request payload
//     smValid/smTaken/smID/smData    slave response handshake and payload
//     error                    sticky: a response arrived with an unknown ID
module memory_bus_arbiter
  import memory_bus_pkg::*;
#(
  parameter int NUM_MASTERS     = 4,
  parameter int DATA_WIDTH      = BUS_DATA_WIDTH,
  parameter int ADDRESS_WIDTH   = BUS_ADDRESS_WIDTH,
  parameter int ID_WIDTH        = BUS_ID_WIDTH,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                                      clock,
  input  logic                                      reset,
  input  logic [NUM_MASTERS-1:0]                    mMsValid,
  output logic [NUM_MASTERS-1:0]                    mMsTaken,
  input  logic [NUM_MASTERS-1:0][ADDRESS_WIDTH-1:0] mMsAddress,
  input  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0]    mMsData,
  input  logic [NUM_MASTERS-1:0]                    mMsWrite,
  output logic                                      mSmValid,
  output logic [ID_WIDTH-1:0]                       mSmID,
  output logic [DATA_WIDTH-1:0]                     mSmData,
  input  logic [NUM_MASTERS-1:0]                    mSmTaken,
  output logic                                      msValid,
  input  logic                                      msTaken,
  output logic [ADDRESS_WIDTH-1:0]                  msAddress,
  output logic [DATA_WIDTH-1:0]                     msData,
  output logic                                      msWrite,
  output logic [ID_WIDTH-1:0]                       msID,
  input  logic                                      smValid,
  output logic                                      smTaken,
  input  logic [ID_WIDTH-1:0]                       smID,
  input  logic [DATA_WIDTH-1:0]                     smData,
  output logic                                      error
);

  localparam int PTR_W = id_width(NUM_MASTERS);
  // One extra bit so NUM_MASTERS itself is representable when 2**ID_WIDTH == NUM_MASTERS.
  localparam logic [ID_WIDTH:0] NUM_ID = (ID_WIDTH + 1)'(NUM_MASTERS);

  req_state_t             req_state, req_state_next;
  bus_req_t               req_q, req_q_next;
  logic [PTR_W-1:0]       ptr, ptr_next;
  logic [NUM_MASTERS-1:0] req_mask;
  logic [NUM_MASTERS-1:0] grant;
  logic [PTR_W-1:0]       grant_idx;
  logic                   grant_valid;
  logic                   can_accept;
  logic                   grant_fire;

  logic                   resp_valid;
  bus_resp_t              resp_q;
  logic                   resp_sel_taken;
  logic                   resp_drain;
  logic                   resp_capture;
  logic                   resp_bad;
  logic                   error_q;

  // ---------------------------------------------------------------------
  // Request stage
  // ---------------------------------------------------------------------

  // The stage frees up in the same cycle its entry is taken, which is what
  // keeps back-to-back transfers running at one per cycle.
  assign can_accept = (req_state == REQ_EMPTY) || msTaken;

  rr_arbiter #(
    .N     (NUM_MASTERS),
    .PTR_W (PTR_W)
  ) u_rr_arbiter (
    .req         (req_mask),
    .ptr         (ptr),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign grant_fire = can_accept && grant_valid;
  assign mMsTaken   = grant_fire ? grant : '0;

  // Next-state for the request entry: load on a grant, empty out when the
  // held entry leaves with no replacement, otherwise hold everything.
  always_comb begin
    req_state_next = req_state;
    req_q_next     = req_q;
    ptr_next       = ptr;
    if (can_accept) begin
      if (grant_valid) begin
        req_state_next = REQ_FULL;
        req_q_next     = '{address: mMsAddress[grant_idx],
                           data:    mMsData[grant_idx],
                           write:   mMsWrite[grant_idx],
                           id:      ID_WIDTH'(grant_idx)};
        ptr_next       = (int'(grant_idx) == NUM_MASTERS - 1) ? '0
                                                              : grant_idx + PTR_W'(1);
      end else begin
        req_state_next = REQ_EMPTY;
      end
    end
  end

  // Request stage registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      req_state <= REQ_EMPTY;
      req_q     <= '0;
      ptr       <= '0;
    end else begin
      req_state <= req_state_next;
      req_q     <= req_q_next;
      ptr       <= ptr_next;
    end
  end

  assign msValid   = (req_state == REQ_FULL);
  assign msAddress = req_q.address;
  assign msData    = req_q.data;
  assign msWrite   = req_q.write;
  assign msID      = req_q.id;

  // ---------------------------------------------------------------------
  // Response stage
  // ---------------------------------------------------------------------

  // Only the addressed master's accept counts; a stored ID is always a
  // valid port index because unknown IDs are never loaded.
  always_comb begin
    resp_sel_taken = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (resp_q.id == ID_WIDTH'(i)) resp_sel_taken = mSmTaken[i];
    end
  end

  assign resp_drain   = resp_valid && resp_sel_taken;
  assign smTaken      = !resp_valid || resp_drain;
  assign resp_capture = smValid && smTaken;
  assign resp_bad     = {1'b0, smID} >= NUM_ID;

  // A good response refills the entry even while it drains (no bubble).
  // A bad one is swallowed and only raises the sticky error.
  always_ff @(posedge clock) begin
    if (reset) begin
      resp_valid <= 1'b0;
      resp_q     <= '0;
      error_q    <= 1'b0;
    end else begin
      if (resp_capture && !resp_bad) begin
        resp_valid <= 1'b1;
        resp_q     <= '{id: smID, data: smData};
      end else if (resp_drain) begin
        resp_valid <= 1'b0;
      end
      if (resp_capture && resp_bad) error_q <= 1'b1;
    end
  end

  assign mSmValid = resp_valid;
  assign mSmID    = resp_q.id;
  assign mSmData  = resp_q.data;
  assign error    = error_q;

  // ---------------------------------------------------------------------
  // Optional per-master read limit
  // ---------------------------------------------------------------------
`ifdef MEMORY_BUS_ARBITER_READ_LIMIT_EN
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [NUM_MASTERS-1:0][CNT_W-1:0] read_count;
  logic [NUM_MASTERS-1:0]            limit_mask;
  logic [NUM_MASTERS-1:0]            read_inc;
  logic [NUM_MASTERS-1:0]            read_dec;

  // Writes never produce a response, so they are never held back.
  always_comb begin
    limit_mask = '0;
    read_inc   = '0;
    read_dec   = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      limit_mask[i] = (read_count[i] == CNT_W'(MAX_OUTSTANDING)) && !mMsWrite[i];
      read_inc[i]   = grant_fire && grant[i] && !mMsWrite[i];
      read_dec[i]   = resp_drain && (resp_q.id == ID_WIDTH'(i));
    end
  end

  assign req_mask = mMsValid & ~limit_mask;

  // Increment and decrement in the same cycle cancel out; the floor guard
  // covers a slave that returns a response nobody asked for.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (reset) begin
        read_count[i] <= '0;
      end else if (read_inc[i] && !read_dec[i]) begin
        read_count[i] <= read_count[i] + CNT_W'(1);
      end else if (read_dec[i] && !read_inc[i] && (read_count[i] != '0)) begin
        read_count[i] <= read_count[i] - CNT_W'(1);
      end
    end
  end
`else
  logic unused_read_limit;

  assign req_mask          = mMsValid;
  assign unused_read_limit = ^MAX_OUTSTANDING;
`endif

endmodule

// File: doc/memory_bus_arbiter.md
Name: memory_bus_arbiter

Overview:
- Sits directly downstream of the ray memory units; funnels up to NUM_MASTERS MemoryBus masters onto the single memory-controller slave port.
- Round-robin request arbiter with a one-entry registered request stage and a one-entry registered response stage.
- Response routing is by ID: the arbiter stamps each request with the master's port index, and the slave echoes it as smID.
- Every ray memory instance must therefore set MASTER_ID equal to its port index.

Parameters:
- NUM_MASTERS, 4, number of upstream masters (2..16).
- DATA_WIDTH, 24, bus data width.
- ADDRESS_WIDTH, 32, bus address width.
- ID_WIDTH, 4, msID/smID width; must satisfy 2**ID_WIDTH >= NUM_MASTERS.
- MAX_OUTSTANDING, 2, per-master read limit; used only with the optional feature.

Ports:
- clock  in  1  single clock; everything is sampled on its rising edge.
- reset  in  1  synchronous, active-high.
- mMsValid  in  [NUM_MASTERS]  per-master request valid.
- mMsTaken  out  [NUM_MASTERS]  per-master request accepted; combinational and one-hot.
- mMsAddress  in  [NUM_MASTERS][ADDRESS_WIDTH]  request address.
- mMsData  in  [NUM_MASTERS][DATA_WIDTH]  write data.
- mMsWrite  in  [NUM_MASTERS]  1 = write, 0 = read.
- mSmValid  out  1  response valid, broadcast to all masters.
- mSmID  out  ID_WIDTH  response ID, broadcast.
- mSmData  out  DATA_WIDTH  response data, broadcast.
- mSmTaken  in  [NUM_MASTERS]  per-master response accept.
- msValid  out  1  downstream request valid.
- msTaken  in  1  downstream request accept.
- msAddress  out  ADDRESS_WIDTH  downstream request address.
- msData  out  DATA_WIDTH  downstream write data.
- msWrite  out  1  downstream write flag.
- msID  out  ID_WIDTH  index of the granted master.
- smValid  in  1  slave response valid.
- smTaken  out  1  slave response accept; combinational.
- smID  in  ID_WIDTH  slave response ID.
- smData  in  DATA_WIDTH  slave response data.
- error  out  1  sticky: a response arrived with smID >= NUM_MASTERS.

Behaviour:
- Reset values: msValid=0, mSmValid=0, error=0, round-robin pointer=0. msAddress, msData, msWrite, msID, mSmID and mSmData reset to 0.
- Reset is synchronous and applies mid-transaction. Any held request or response is dropped, and the counters clear.
- Request stage (states EMPTY/FULL, held as the msValid register):
  - The stage can accept when EMPTY, or when FULL and msValid&&msTaken this cycle. This gives one transfer per cycle.
  - When it can accept, grant the first requesting master at or after the pointer, wrapping modulo NUM_MASTERS.
  - mMsTaken[g]=1 in the same cycle as the grant. Capture address/data/write, msID=g and msValid=1 on the next edge.
  - The pointer then moves to (g+1) mod NUM_MASTERS; it holds when nothing is granted.
  - If FULL and not taken, all outputs hold stable and mMsTaken is all zeros.
  - Latency: grant at cycle t gives msValid at t+1.
  - Upstream msID inputs are not used; the arbiter overwrites them.
- Response stage (one entry):
  - smTaken = (entry empty) || (entry valid and the addressed master's mSmTaken is high).
  - Capture smID/smData on smValid&&smTaken; mSmValid=1 next cycle.
  - The entry drains when mSmTaken[mSmID]=1. The mSmTaken bits of other masters are ignored.
  - A simultaneous drain and capture replaces the entry with no bubble.
- Unknown response ID: if smID >= NUM_MASTERS, the response is accepted and discarded, never presented, and error is set and held until reset.
- A write produces no response.

Optional Feature:
- Macro: MEMORY_BUS_ARBITER_READ_LIMIT_EN.
- Defined:
  - Each master has a read counter of width $clog2(MAX_OUTSTANDING+1).
  - It increments on a read grant and decrements when that master's response drains; increment plus decrement in the same cycle leaves it unchanged.
  - A master whose count equals MAX_OUTSTANDING is masked from arbitration, and the pointer skips it.
  - Writes are never masked.
- Undefined: no counters and no masking.

Decomposition:
- memory_bus_pkg holds:
  - the request struct (address, data, write, id);
  - the response struct (id, data);
  - the id_width(n) function.
- Sub-module rr_arbiter: purely combinational. Inputs are the request mask and pointer; outputs are a one-hot grant and the grant index. It is instantiated once.

Test Plan:
- Single master: master 2 issues a read to 0x100 while msTaken=1 → mMsTaken[2] in cycle t; at t+1, msValid=1, msAddress=0x100, msID=2, msWrite=0.
- Fairness: all 4 masters hold valid and msTaken is always 1 → grants are 0,1,2,3,0,1 on consecutive cycles, with no idle cycle.
- Backpressure: msTaken=0 for 5 cycles while FULL → msAddress/msID stay stable and mMsTaken=0. When msTaken rises, the next grant happens in the same cycle.
- Response routing: smValid, smID=1, smData=0xABCDEF → one cycle later mSmValid=1, mSmID=1, mSmData=0xABCDEF. It holds while mSmTaken=4'b0001 and drains on 4'b0010.
- Bad ID: with NUM_MASTERS=4, inject smID=7 → smTaken=1, mSmValid stays 0, error=1 until reset.
- Read limit (with macro, MAX_OUTSTANDING=2): master 0 issues 3 reads with no responses → only 2 are granted. After one response drains, the third is granted.
